// File: rtl/cv32e40p_shadow_restore_controller_pkg.sv
// rtl/cv32e40p_shadow_restore_controller_pkg.sv - shared types and constants for the shadow save/restore path
package cv32e40p_shadow_restore_controller_pkg;

    localparam int unsigned SHADOW_WORD_BYTES        = 4;
    localparam int unsigned SHADOW_NUM_SAVES_DEFAULT = 7;

    typedef enum logic [1:0] {
        SHADOW_IDLE  = 2'd0,
        SHADOW_LOAD  = 2'd1,
        SHADOW_DRAIN = 2'd2
    } shadow_state_e;

    // Stack frames grow downwards, so each following word sits one word below the previous one.
    function automatic logic [31:0] shadow_prev_word(input logic [31:0] addr);
        return addr - 32'(SHADOW_WORD_BYTES);
    endfunction

endpackage

// File: rtl/cv32e40p_shadow_restore_controller_if.sv
// rtl/cv32e40p_shadow_restore_controller_if.sv - OBI-style data memory port used by the restore path
interface cv32e40p_shadow_restore_controller_if;

    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/cv32e40p_shadow_restore_controller.sv
// rtl/cv32e40p_shadow_restore_controller.sv - reloads the shadow register file from the stack on interrupt return
module cv32e40p_shadow_restore_controller
    import cv32e40p_shadow_restore_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 6,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned NUM_SHADOW_SAVES = SHADOW_NUM_SAVES_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  setback_i,
    input  logic                  restore_i,
    input  logic [31:0]           restore_sp_i,
    output logic                  restore_ready_o,
    output logic                  restore_done_o,
    output logic [ADDR_WIDTH-1:0] restore_level_o,
    output logic                  shadow_reg_we_o,
    output logic [ADDR_WIDTH-1:0] shadow_reg_waddr_o,
    output logic [DATA_WIDTH-1:0] shadow_reg_wdata_o,
    cv32e40p_shadow_restore_controller_if.master mem
);

    localparam int unsigned           OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_SHADOW_SAVES - 1);
    localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    shadow_state_e         state_q, state_d;
    logic [31:0]           stack_q, stack_d;
    logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH-1:0] resp_idx_q, resp_idx_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  done_q, done_d;
    logic                  issue;
    logic                  grant;
    logic                  resp;

    // Next-state, request issue and response acceptance decode
    always_comb begin
        state_d       = state_q;
        stack_d       = stack_q;
        issue_cnt_d   = issue_cnt_q;
        resp_idx_d    = resp_idx_q;
        outstanding_d = outstanding_q;
        done_d        = 1'b0;
        issue         = 1'b0;
        resp          = 1'b0;

        case (state_q)
            SHADOW_IDLE: begin
                if (restore_i) begin
                    state_d     = SHADOW_LOAD;
                    stack_d     = shadow_prev_word(restore_sp_i);
                    issue_cnt_d = LAST_IDX;
                    resp_idx_d  = LAST_IDX;
                end
            end
            SHADOW_LOAD: begin
                issue = (outstanding_q < OUT_MAX);
                // A response with nothing in flight is a protocol error; never let it underflow.
                resp  = mem.rvalid && (outstanding_q != '0);
            end
            SHADOW_DRAIN: begin
                resp  = mem.rvalid && (outstanding_q != '0);
            end
            default: state_d = SHADOW_IDLE;
        endcase

        grant = issue && mem.gnt;

        if (grant) begin
            stack_d = shadow_prev_word(stack_q);
            if (issue_cnt_q == '0) begin
                state_d = SHADOW_DRAIN;
            end else begin
                issue_cnt_d = issue_cnt_q - 1'b1;
            end
        end

        // The last word always arrives in DRAIN because it can only be answered after its grant.
        if (resp) begin
            if (resp_idx_q == '0) begin
                state_d    = SHADOW_IDLE;
                resp_idx_d = LAST_IDX;
                done_d     = 1'b1;
            end else begin
                resp_idx_d = resp_idx_q - 1'b1;
            end
        end

        case ({grant, resp})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State and counter registers; setback behaves like a synchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= SHADOW_IDLE;
            stack_q       <= '0;
            issue_cnt_q   <= LAST_IDX;
            resp_idx_q    <= LAST_IDX;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else if (setback_i) begin
            state_q       <= SHADOW_IDLE;
            stack_q       <= '0;
            issue_cnt_q   <= LAST_IDX;
            resp_idx_q    <= LAST_IDX;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stack_q       <= stack_d;
            issue_cnt_q   <= issue_cnt_d;
            resp_idx_q    <= resp_idx_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
        end
    end

    assign mem.req            = issue;
    assign mem.we             = 1'b0;
    assign mem.be             = issue ? 4'b1111 : 4'b0000;
    assign mem.addr           = issue ? stack_q : 32'h0;

    // Write-back is combinational so a register lands in the same cycle its rvalid arrives.
    assign shadow_reg_we_o    = resp;
    assign shadow_reg_waddr_o = resp_idx_q;
    assign shadow_reg_wdata_o = mem.rdata[DATA_WIDTH-1:0];

    assign restore_ready_o    = (state_q == SHADOW_IDLE);
    assign restore_done_o     = done_q;
    assign restore_level_o    = resp_idx_q;

`ifndef SYNTHESIS
    // Handshake sanity checks outside reset
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(restore_i && state_q != SHADOW_IDLE))
                else $error("shadow restore: restore request ignored while busy");
            assert (!(mem.rvalid && state_q == SHADOW_IDLE))
                else $warning("shadow restore: rvalid dropped while idle");
            assert (!(setback_i && outstanding_q != '0))
                else $error("shadow restore: setback with reads in flight");
            assert (!(mem.rvalid && state_q != SHADOW_IDLE && outstanding_q == '0))
                else $error("shadow restore: response with no read in flight");
            assert (!(grant && !resp && outstanding_q == OUT_MAX))
                else $error("shadow restore: outstanding counter overflow");
        end
    end
`endif

endmodule
